// File: rtl/risc5_intc_timer_if.sv
// CPU data-bus view of the interrupt controller / timer register window.
// The CPU side drives address and strobes; the peripheral answers with hit and read data.
interface risc5_intc_timer_if;
  logic [23:0] adr;
  logic        rd;
  logic        wr;
  logic        ben;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;

  modport master (output adr, rd, wr, ben, wdata, input hit, rdata);
  modport slave  (input adr, rd, wr, ben, wdata, output hit, rdata);
endinterface

// File: rtl/risc5_intc_timer.sv
// Memory-mapped interrupt controller with millisecond timer for the RISC5 I/O window.
// Produces a fresh irq rising edge after each acknowledge while requests remain.
module risc5_intc_timer #(
  parameter logic [23:0] BASE       = 24'hFFFFC0,
  parameter int          CLK_PER_MS = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  risc5_intc_timer_if.slave     bus,
  input  logic [6:0]            src,
  output logic                  irq
);

  localparam logic [19:0] PRESC_RLD = 20'(CLK_PER_MS - 1);
  localparam logic [2:0]  OFF_PEND  = 3'd0;
  localparam logic [2:0]  OFF_ENB   = 3'd1;
  localparam logic [2:0]  OFF_MSCNT = 3'd2;
  localparam logic [2:0]  OFF_CMP   = 3'd3;
  localparam logic [2:0]  OFF_VEC   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ASSERT = 2'b01,
    GAP    = 2'b10
  } state_t;

  logic [7:0]  pend_q, pend_d, enb_q, enb_d;
  logic [31:0] mscnt_q, mscnt_d, cmp_q, cmp_d;
  logic [19:0] presc_q, presc_d;
  logic [6:0]  sync1_q, sync2_q, prev_q;
  logic [1:0]  arm_q, arm_d;
  state_t      state_q, state_d;

  logic [2:0]  off;
  logic        we, tick, cmp_evt, act, ackw;
  logic [31:0] mscnt_inc;
  logic [6:0]  rise;
  logic [7:0]  req, clr;
  logic [2:0]  vec_idx;
  logic        unused_ok;

  assign unused_ok = ^{bus.adr[1:0], bus.rd};

  assign bus.hit = (bus.adr[23:5] == BASE[23:5]);
  assign off     = bus.adr[4:2];
  assign we      = bus.wr & bus.hit & ~bus.ben;
  assign ackw    = we & ((off == OFF_PEND) | (off == OFF_ENB));

  // Edge detection stays blind until the synchronizer has refilled after reset,
  // so a source already high at reset release is not mistaken for an event.
  assign rise = (arm_q == 2'd3) ? (sync2_q & ~prev_q) : 7'd0;

  assign tick      = (presc_q == 20'd0);
  assign mscnt_inc = mscnt_q + 32'd1;
  assign req       = pend_q & enb_q;
  assign act       = |req;
  assign irq       = state_q[0];

  always_comb begin
    vec_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.hit) begin
      case (off)
        OFF_PEND:  bus.rdata = {24'd0, pend_q};
        OFF_ENB:   bus.rdata = {24'd0, enb_q};
        OFF_MSCNT: bus.rdata = mscnt_q;
        OFF_CMP:   bus.rdata = cmp_q;
        OFF_VEC:   bus.rdata = {act, 28'd0, vec_idx};
        default:   bus.rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    enb_d   = enb_q;
    cmp_d   = cmp_q;
    mscnt_d = mscnt_q;
    presc_d = tick ? PRESC_RLD : presc_q - 20'd1;
    cmp_evt = 1'b0;
    clr     = 8'd0;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

    if (we && off == OFF_ENB) enb_d = bus.wdata[7:0];
    if (we && off == OFF_CMP) cmp_d = bus.wdata;
    if (we && off == OFF_PEND) clr = bus.wdata[7:0];

    // A software load beats a same-cycle tick: no increment, no compare event.
    if (we && off == OFF_MSCNT) begin
      mscnt_d = bus.wdata;
      presc_d = PRESC_RLD;
    end else if (tick) begin
      mscnt_d = mscnt_inc;
      cmp_evt = (mscnt_inc == cmp_q);
    end

    pend_d = (pend_q & ~clr) | {rise, cmp_evt};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (act) state_d = ASSERT;
      ASSERT:  if (ackw) state_d = GAP;
               else if (!act) state_d = IDLE;
      GAP:     state_d = act ? ASSERT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= 8'd0;
      enb_q   <= 8'd0;
      mscnt_q <= 32'd0;
      cmp_q   <= 32'd0;
      presc_q <= PRESC_RLD;
      sync1_q <= 7'd0;
      sync2_q <= 7'd0;
      prev_q  <= 7'd0;
      arm_q   <= 2'd0;
      state_q <= IDLE;
    end else begin
      pend_q  <= pend_d;
      enb_q   <= enb_d;
      mscnt_q <= mscnt_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      sync1_q <= src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= arm_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_risc5_intc_timer.sv
// Directed bench for risc5_intc_timer: register access, source events, timer compare,
// irq re-edge behaviour and asynchronous reset.
module tb_risc5_intc_timer;

  localparam logic [23:0] BASE = 24'hFFFFC0;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] src;
  logic       irq;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [31:0] d;

  risc5_intc_timer_if bus ();

  risc5_intc_timer #(.BASE(BASE), .CLK_PER_MS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .src (src),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [31:0] data, input logic byte_en = 1'b0);
    bus.adr   = BASE + 24'(off * 4);
    bus.wdata = data;
    bus.ben   = byte_en;
    bus.wr    = 1'b1;
    step();
    bus.wr    = 1'b0;
    bus.ben   = 1'b0;
  endtask

  task automatic rd_reg(input int off, output logic [31:0] data);
    bus.adr = BASE + 24'(off * 4);
    bus.rd  = 1'b1;
    #1;
    data    = bus.rdata;
    bus.rd  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; src = 7'd0;
    bus.adr = 24'd0; bus.rd = 1'b0; bus.wr = 1'b0; bus.ben = 1'b0; bus.wdata = 32'd0;
    #2;
    for (int i = 0; i < 8; i++) begin
      rd_reg(i, d);
      chk($sformatf("rst_rd%0d", i), d, 32'd0);
    end
    chk("rst_hit", {31'd0, bus.hit}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    bus.adr = BASE + 24'd32;
    #1;
    chk("miss_hit", {31'd0, bus.hit}, 32'd0);
    chk("miss_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) step();

    // single source, enabled
    wr_reg(1, 32'h02);
    src[0] = 1'b1;
    step(); step();
    rd_reg(0, d); chk("t1_pend_2clk", d, 32'h0);
    step();
    rd_reg(0, d); chk("t1_pend_3clk", d, 32'h02);
    chk("t1_irq_3clk", {31'd0, irq}, 32'd0);
    step();
    chk("t1_irq_4clk", {31'd0, irq}, 32'd1);
    step();
    src[0] = 1'b0;
    rd_reg(4, d); chk("t1_vec", d, 32'h80000001);
    wr_reg(0, 32'h02);
    chk("t1_irq_ack", {31'd0, irq}, 32'd0);
    step();
    chk("t1_irq_ack1", {31'd0, irq}, 32'd0);
    step();
    chk("t1_irq_ack2", {31'd0, irq}, 32'd0);
    rd_reg(0, d); chk("t1_pend_clr", d, 32'h0);

    // two simultaneous sources, re-edge after partial ack
    wr_reg(1, 32'h06);
    src[1:0] = 2'b11;
    step(); step(); step();
    chk("t2_irq_3clk", {31'd0, irq}, 32'd0);
    step();
    chk("t2_irq_4clk", {31'd0, irq}, 32'd1);
    src[1:0] = 2'b00;
    step();
    chk("t2_irq_hold", {31'd0, irq}, 32'd1);
    rd_reg(4, d); chk("t2_vec1", d, 32'h80000001);
    wr_reg(0, 32'h02);
    chk("t2_irq_gap", {31'd0, irq}, 32'd0);
    step();
    chk("t2_irq_reedge", {31'd0, irq}, 32'd1);
    rd_reg(4, d); chk("t2_vec2", d, 32'h80000002);
    wr_reg(0, 32'h04);
    chk("t2_irq_ack", {31'd0, irq}, 32'd0);
    step();
    chk("t2_irq_idle", {31'd0, irq}, 32'd0);
    rd_reg(4, d); chk("t2_vec0", d, 32'h0);

    // byte write ignored; set beats simultaneous clear
    wr_reg(1, 32'hFF, 1'b1);
    rd_reg(1, d); chk("t3_enb_byte", d, 32'h06);
    src[2] = 1'b1;
    step(); step();
    wr_reg(0, 32'h08);
    rd_reg(0, d); chk("t3_set_wins", d, 32'h08);
    src[2] = 1'b0;
    wr_reg(0, 32'h08);
    rd_reg(0, d); chk("t3_pend_clr", d, 32'h0);
    rd_reg(5, d); chk("t3_off5", d, 32'h0);

    // timer compare and wrap
    wr_reg(1, 32'h01);
    wr_reg(3, 32'd3);
    wr_reg(2, 32'd0);
    repeat (11) step();
    rd_reg(2, d); chk("t4_ms_11", d, 32'd2);
    rd_reg(0, d); chk("t4_pend_11", d, 32'h0);
    step();
    rd_reg(2, d); chk("t4_ms_12", d, 32'd3);
    rd_reg(0, d); chk("t4_pend_12", d, 32'h01);
    step();
    chk("t4_irq", {31'd0, irq}, 32'd1);
    wr_reg(0, 32'h01);
    chk("t4_irq_ack", {31'd0, irq}, 32'd0);
    wr_reg(3, 32'd0);
    wr_reg(2, 32'hFFFFFFFF);
    rd_reg(3, d); chk("t4_cmp_rd", d, 32'd0);
    repeat (3) step();
    rd_reg(2, d); chk("t4_ms_pre", d, 32'hFFFFFFFF);
    rd_reg(0, d); chk("t4_pend_pre", d, 32'h0);
    step();
    rd_reg(2, d); chk("t4_ms_wrap", d, 32'd0);
    rd_reg(0, d); chk("t4_pend_wrap", d, 32'h01);

    // asynchronous reset mid-assert
    wr_reg(0, 32'h01);
    wr_reg(1, 32'h80);
    src[6] = 1'b1;
    repeat (4) step();
    chk("t5_irq_pre", {31'd0, irq}, 32'd1);
    rd_reg(0, d); chk("t5_pend_pre", d, 32'h80);
    rst = 1'b0;
    #1;
    chk("t5_irq_rst", {31'd0, irq}, 32'd0);
    rd_reg(0, d); chk("t5_pend_rst", d, 32'h0);
    rd_reg(1, d); chk("t5_enb_rst", d, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (6) step();
    rd_reg(0, d); chk("t5_pend_hold", d, 32'h0);
    chk("t5_irq_hold", {31'd0, irq}, 32'd0);
    src[6] = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
